// File: rtl/demo_scene_sequencer.sv
// Frame-synchronous scene/fade scheduler for the demoscene VGA pipeline.
// Optional macro SCENE_SHUFFLE_EN: LFSR-driven pseudo-random scene order.
module demo_scene_sequencer #(
  parameter int NUM_SCENES  = 4,
  parameter int SCENE_W     = 2,
  parameter int FADE_W      = 2,
  parameter int STEP_FRAMES = 8,
  parameter int HOLD_FRAMES = 240
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               pause,
  input  logic               skip,
  output logic [SCENE_W-1:0] scene_id,
  output logic [FADE_W-1:0]  fade,
  output logic               scene_change,
  output logic [15:0]        frame_count
);

  localparam int STEP_W = $clog2(STEP_FRAMES + 1);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [FADE_W-1:0]  FADE_MAX  = {FADE_W{1'b1}};
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_FRAMES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [SCENE_W-1:0] SCENE_LAST = SCENE_W'(NUM_SCENES - 1);

  typedef enum logic [1:0] {
    FADE_IN  = 2'b00,
    HOLD     = 2'b01,
    FADE_OUT = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [SCENE_W-1:0] scene_id_q, scene_id_d;
  logic [FADE_W-1:0]  fade_q, fade_d;
  logic               scene_change_q, scene_change_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               advance;
  logic [SCENE_W-1:0] next_scene;

`ifdef SCENE_SHUFFLE_EN
  logic [7:0]         lfsr_q, lfsr_d;
  logic [SCENE_W-1:0] offset;

  // Pick the next scene: skip ahead by a random offset that never lands back
  // on the current scene.
  always_comb begin
    offset = lfsr_q[SCENE_W-1:0];
    if (offset == SCENE_LAST) offset = '0;
    next_scene = scene_id_q + SCENE_W'(1) + offset;
  end
`else
  // Plain round-robin through the scenes.
  always_comb begin
    if (scene_id_q == SCENE_LAST) next_scene = '0;
    else next_scene = scene_id_q + SCENE_W'(1);
  end
`endif

  // Next-state logic; only a frame_start edge may change anything.
  always_comb begin
    state_d        = state_q;
    step_cnt_d     = step_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    scene_id_d     = scene_id_q;
    fade_d         = fade_q;
    frame_count_d  = frame_count_q;
    scene_change_d = 1'b0;
    advance        = 1'b0;
`ifdef SCENE_SHUFFLE_EN
    lfsr_d         = lfsr_q;
`endif
    if (frame_start) begin
      frame_count_d = frame_count_q + 16'd1;
`ifdef SCENE_SHUFFLE_EN
      lfsr_d = {lfsr_q[6:0],
                lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
      if (!pause) begin
        case (state_q)
          FADE_IN: begin
            if (skip) begin
              state_d    = FADE_OUT;
              step_cnt_d = '0;
            end else if (step_cnt_q == STEP_LAST) begin
              step_cnt_d = '0;
              if (fade_q != FADE_MAX) fade_d = fade_q + FADE_W'(1);
              if (fade_d == FADE_MAX) begin
                state_d    = HOLD;
                hold_cnt_d = '0;
              end
            end else begin
              step_cnt_d = step_cnt_q + STEP_W'(1);
            end
          end
          HOLD: begin
            if (skip || hold_cnt_q == HOLD_LAST) begin
              state_d    = FADE_OUT;
              step_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
          FADE_OUT: begin
            if (step_cnt_q == STEP_LAST) begin
              step_cnt_d = '0;
              // Saturate: a skip from fade 0 must not wrap to full.
              if (fade_q != '0) fade_d = fade_q - FADE_W'(1);
              if (fade_d == '0) begin
                advance = 1'b1;
                state_d = FADE_IN;
              end
            end else begin
              step_cnt_d = step_cnt_q + STEP_W'(1);
            end
          end
          default: begin
            state_d    = FADE_IN;
            fade_d     = '0;
            step_cnt_d = '0;
            hold_cnt_d = '0;
          end
        endcase
        if (advance) begin
          scene_id_d     = next_scene;
          scene_change_d = 1'b1;
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FADE_IN;
      step_cnt_q     <= '0;
      hold_cnt_q     <= '0;
      scene_id_q     <= '0;
      fade_q         <= '0;
      scene_change_q <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      step_cnt_q     <= step_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      scene_id_q     <= scene_id_d;
      fade_q         <= fade_d;
      scene_change_q <= scene_change_d;
      frame_count_q  <= frame_count_d;
    end
  end

`ifdef SCENE_SHUFFLE_EN
  // Shuffle LFSR, free-running on frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end
`endif

  assign scene_id     = scene_id_q;
  assign fade         = fade_q;
  assign scene_change = scene_change_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Bench for demo_scene_sequencer with STEP_FRAMES=2, HOLD_FRAMES=4.
// Table-driven frame vectors plus hand sequences for wrap and async reset.
module tb_demo_scene_sequencer;

  logic       clk;
  logic       rst_n;
  logic       frame_start;
  logic       pause;
  logic       skip;
  logic [1:0] scene_id;
  logic [1:0] fade;
  logic       scene_change;
  logic [15:0] frame_count;

  int n_tests;
  int n_fail;
  int gap;

  demo_scene_sequencer #(
    .NUM_SCENES (4),
    .SCENE_W    (2),
    .FADE_W     (2),
    .STEP_FRAMES(2),
    .HOLD_FRAMES(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pause       (pause),
    .skip        (skip),
    .scene_id    (scene_id),
    .fade        (fade),
    .scene_change(scene_change),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       skip;
    bit       pause;
    logic [1:0] fade;
    logic [1:0] scene;
    bit       chg;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit r, bit s, bit p,
                              int f, int sc, bit c);
    vec_t v;
    v.rst   = r;
    v.skip  = s;
    v.pause = p;
    v.fade  = 2'(f);
    v.scene = 2'(sc);
    v.chg   = c;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One frame_start pulse; returns 1 cycle after the sampling edge.
  task automatic do_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic idle_gap();
    repeat (gap) @(negedge clk);
  endtask

  int fa[16];
  int fb[13];
  int fc[14];
  int fcm;
  int chg_cnt;
  int exp_sc;
  int repeats;
  int prev;
  logic [3:0] visited;
  logic [7:0] ml;
  logic [1:0] off;

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    pause       = 1'b0;
    skip        = 1'b0;
    n_tests     = 0;
    n_fail      = 0;
    gap         = 2;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst.scene", scene_id, 0);
    check("rst.fade", fade, 0);
    check("rst.chg", scene_change, 0);
    check("rst.fcount", frame_count, 0);

`ifndef SCENE_SHUFFLE_EN
    // Full scene: fade in, hold, fade out, advance.
    fa = '{0,1,1,2,2,3,3,3,3,3,3,2,2,1,1,0};
    for (int i = 0; i < 16; i++)
      vq.push_back(mk(i == 0, 0, 0, fa[i], (i == 15) ? 1 : 0, i == 15));
    // Skip during HOLD on frame 7.
    fb = '{0,1,1,2,2,3,3,3,2,2,1,1,0};
    for (int i = 0; i < 13; i++)
      vq.push_back(mk(i == 0, i == 6, 0, fb[i],
                      (i == 12) ? 1 : 0, i == 12));
    // Pause on frames 3-10, skip raised while paused.
    fc = '{0,1,1,1,1,1,1,1,1,1,1,2,2,3};
    for (int i = 0; i < 14; i++)
      vq.push_back(mk(i == 0, i == 4 || i == 5, i >= 2 && i <= 9,
                      fc[i], 0, 0));

    fcm = 0;
    gap = 98;
    foreach (vq[i]) begin
      if (vq[i].rst) begin
        do_reset();
        fcm = 0;
      end
      skip  = vq[i].skip;
      pause = vq[i].pause;
      do_frame();
      fcm++;
      check($sformatf("vec%0d.fade", i), fade, vq[i].fade);
      check($sformatf("vec%0d.scene", i), scene_id, vq[i].scene);
      check($sformatf("vec%0d.chg", i), scene_change, vq[i].chg);
      check($sformatf("vec%0d.fcount", i), frame_count, fcm);
      @(negedge clk);
      check($sformatf("vec%0d.chg_low", i), scene_change, 0);
      skip  = 1'b0;
      pause = 1'b0;
      if (i < 16) idle_gap();
    end
    gap = 2;

    // Four full scenes: scene order and single-pulse wrap.
    do_reset();
    chg_cnt = 0;
    for (int f = 1; f <= 64; f++) begin
      do_frame();
      if (scene_change) chg_cnt++;
      if (f % 16 == 0) begin
        check($sformatf("seq.scene_f%0d", f), scene_id, (f / 16) % 4);
        check($sformatf("seq.chg_f%0d", f), scene_change, 1);
      end
      @(negedge clk);
      if (scene_change) chg_cnt++;
    end
    check("seq.chg_total", chg_cnt, 4);
    check("seq.fcount", frame_count, 64);

    // Async reset between edges while in HOLD of scene 1.
    do_reset();
    for (int f = 0; f < 23; f++) do_frame();
    check("ar.pre_scene", scene_id, 1);
    check("ar.pre_fade", fade, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar.scene", scene_id, 0);
    check("ar.fade", fade, 0);
    check("ar.fcount", frame_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int f = 1; f <= 16; f++) begin
      do_frame();
      if (f == 15) check("ar.scene_f15", scene_id, 0);
      if (f == 16) begin
        check("ar.scene_f16", scene_id, 1);
        check("ar.chg_f16", scene_change, 1);
      end
    end
`else
    // Shuffled order: no repeats, full coverage, LFSR-matched first pick.
    do_reset();
    ml = 8'hA5;
    for (int k = 0; k < 15; k++)
      ml = {ml[6:0], ml[7] ^ ml[5] ^ ml[4] ^ ml[3]};
    off = ml[1:0];
    if (off == 2'd3) off = 2'd0;
    exp_sc = (1 + off) % 4;
    repeats = 0;
    prev = 0;
    visited = 4'b0001;
    for (int a = 0; a < 200; a++) begin
      for (int f = 0; f < 16; f++) do_frame();
      if (a == 0) begin
        check("shuf.first", scene_id, exp_sc);
        check("shuf.chg", scene_change, 1);
      end
      if (scene_id == 2'(prev)) repeats++;
      visited[scene_id] = 1'b1;
      prev = scene_id;
    end
    check("shuf.repeats", repeats, 0);
    check("shuf.visited", visited, 15);
    check("shuf.fcount", frame_count, 3200);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
